// File: rtl/pipeline_pkg.sv
// Shared definitions for the RV32I pipeline stages: PC constants, bubble
// instruction and the IF/ID bundle consumed by decode and the hazard unit.
package pipeline_pkg;

    localparam int          PC_W     = 32;
    localparam logic [31:0] PC_INC   = 32'd4;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     inst;
        logic            valid;
    } ifid_t;

endpackage

// File: rtl/pipeline_if_stage_if.sv
// Fetch-stage bus: hazard/branch control in, instruction memory port, IF/ID out.
// IF_PERF_CNT_EN adds the fetch and bubble counter outputs.
interface pipeline_if_stage_if;
    import pipeline_pkg::*;

    logic            Stall_IF;
    logic            Redirect_IF;
    logic [PC_W-1:0] Target_IF;
    logic [31:0]     Inst_in_IF;
    logic [PC_W-1:0] PC_out_IF;
    logic [PC_W-1:0] PC_IFID;
    logic [31:0]     Inst_IFID;
    logic            Valid_IFID;
`ifdef IF_PERF_CNT_EN
    logic [31:0]     Fetch_cnt_IF;
    logic [31:0]     Bubble_cnt_IF;
`endif

    modport master (
        input  Stall_IF, Redirect_IF, Target_IF, Inst_in_IF,
        output PC_out_IF, PC_IFID, Inst_IFID, Valid_IFID
`ifdef IF_PERF_CNT_EN
        , output Fetch_cnt_IF, Bubble_cnt_IF
`endif
    );

    modport slave (
        output Stall_IF, Redirect_IF, Target_IF, Inst_in_IF,
        input  PC_out_IF, PC_IFID, Inst_IFID, Valid_IFID
`ifdef IF_PERF_CNT_EN
        , input Fetch_cnt_IF, Bubble_cnt_IF
`endif
    );

endinterface

// File: rtl/pipeline_reg_ifid.sv
// IF/ID pipeline register: flush loads the bubble, hold keeps contents,
// flush wins over hold; reset loads the bubble.
module pipeline_reg_ifid
    import pipeline_pkg::*;
#(
    parameter logic [31:0] NOP_INST_P = NOP_INST
) (
    input  logic  clk_i,
    input  logic  rst_n_i,
    input  logic  hold_i,
    input  logic  flush_i,
    input  ifid_t d_i,
    output ifid_t q_o
);

    localparam ifid_t BUBBLE = '{pc: '0, inst: NOP_INST_P, valid: 1'b0};

    ifid_t ifid_q;
    ifid_t ifid_d;

    always_comb begin
        ifid_d = ifid_q;
        if (flush_i) begin
            ifid_d = BUBBLE;
        end else if (!hold_i) begin
            ifid_d = d_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ifid_q <= BUBBLE;
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign q_o = ifid_q;

endmodule

// File: rtl/pipeline_if_stage.sv
// Instruction-fetch stage: PC register, next-PC mux and IF/ID register.
// IF_PERF_CNT_EN adds free-running fetch and bubble counters.
module pipeline_if_stage
    import pipeline_pkg::*;
#(
    parameter logic [PC_W-1:0] PC_RESET = 32'h0000_0000,
    parameter logic [31:0]     NOP_INST = pipeline_pkg::NOP_INST
) (
    input  logic                clk_IF,
    input  logic                rst_IF,
    pipeline_if_stage_if.master bus
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic            advance;
    ifid_t           ifid_in;
    ifid_t           ifid_out;

    assign advance = !bus.Redirect_IF && !bus.Stall_IF;

    // Redirect targets are force-aligned to a word boundary.
    always_comb begin
        pc_d = pc_q;
        if (bus.Redirect_IF) begin
            pc_d = bus.Target_IF & ~32'h0000_0003;
        end else if (!bus.Stall_IF) begin
            pc_d = pc_q + PC_INC;
        end
    end

    always_ff @(posedge clk_IF or negedge rst_IF) begin
        if (!rst_IF) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign ifid_in = '{pc: pc_q, inst: bus.Inst_in_IF, valid: 1'b1};

    pipeline_reg_ifid #(
        .NOP_INST_P (NOP_INST)
    ) u_ifid (
        .clk_i   (clk_IF),
        .rst_n_i (rst_IF),
        .hold_i  (bus.Stall_IF),
        .flush_i (bus.Redirect_IF),
        .d_i     (ifid_in),
        .q_o     (ifid_out)
    );

    assign bus.PC_out_IF  = pc_q;
    assign bus.PC_IFID    = ifid_out.pc;
    assign bus.Inst_IFID  = ifid_out.inst;
    assign bus.Valid_IFID = ifid_out.valid;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] fetch_cnt_d;
    logic [31:0] bubble_cnt_q;
    logic [31:0] bubble_cnt_d;

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (advance) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end else begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_IF or negedge rst_IF) begin
        if (!rst_IF) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.Fetch_cnt_IF  = fetch_cnt_q;
    assign bus.Bubble_cnt_IF = bubble_cnt_q;
`else
    logic unused_advance;
    assign unused_advance = advance;
`endif

endmodule

// File: tb/tb_pipeline_if_stage.sv
// Directed bench for pipeline_if_stage: vector table of per-edge controls and
// expected outputs, followed by asynchronous-reset and post-release sequences.
module tb_pipeline_if_stage;
    import pipeline_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    pipeline_if_stage_if bus();

    pipeline_if_stage dut (
        .clk_IF (clk),
        .rst_IF (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] pc);
        return pc ^ 32'h5A5A_0003;
    endfunction

    assign bus.Inst_in_IF = rom(bus.PC_out_IF);

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] target;
        logic [31:0] exp_pc;
        logic [31:0] exp_pc_ifid;
        logic [31:0] exp_inst;
        logic        exp_valid;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [31:0] pc, input logic [31:0] pc_ifid,
                                 input logic [31:0] inst, input logic valid);
        check({tag, " PC_out_IF"},  bus.PC_out_IF,  pc);
        check({tag, " PC_IFID"},    bus.PC_IFID,    pc_ifid);
        check({tag, " Inst_IFID"},  bus.Inst_IFID,  inst);
        check({tag, " Valid_IFID"}, {31'd0, bus.Valid_IFID}, {31'd0, valid});
    endtask

    initial begin
        logic [31:0] exp_fetch;
        logic [31:0] exp_bubble;
        exp_fetch  = 0;
        exp_bubble = 0;
        checks = 0;
        errors = 0;

        //            stall  redir target         pc            pc_ifid       inst                 valid
        vecs[0]  = '{1'b0, 1'b0, 32'h0,        32'h4,        32'h0,        rom(32'h0),          1'b1};
        vecs[1]  = '{1'b0, 1'b0, 32'h0,        32'h8,        32'h4,        rom(32'h4),          1'b1};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,        32'h8,        32'h4,        rom(32'h4),          1'b1};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,        32'h8,        32'h4,        rom(32'h4),          1'b1};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,        32'hC,        32'h8,        rom(32'h8),          1'b1};
        vecs[5]  = '{1'b1, 1'b1, 32'h103,      32'h100,      32'h0,        32'h0000_0013,       1'b0};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,        32'h104,      32'h100,      rom(32'h100),        1'b1};
        vecs[7]  = '{1'b0, 1'b1, 32'h40,       32'h40,       32'h0,        32'h0000_0013,       1'b0};
        vecs[8]  = '{1'b0, 1'b1, 32'h80,       32'h80,       32'h0,        32'h0000_0013,       1'b0};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,        32'h84,       32'h80,       rom(32'h80),         1'b1};
        vecs[10] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,      32'h0000_0013,       1'b0};
        vecs[11] = '{1'b0, 1'b0, 32'h0,        32'h0,        32'hFFFF_FFFC, rom(32'hFFFF_FFFC), 1'b1};
        vecs[12] = '{1'b0, 1'b1, 32'h202,      32'h200,      32'h0,        32'h0000_0013,       1'b0};
        vecs[13] = '{1'b1, 1'b0, 32'h0,        32'h200,      32'h0,        32'h0000_0013,       1'b0};
        vecs[14] = '{1'b0, 1'b0, 32'h0,        32'h204,      32'h200,      rom(32'h200),        1'b1};

        bus.Stall_IF    = 1'b0;
        bus.Redirect_IF = 1'b0;
        bus.Target_IF   = 32'h0;
        rst_n = 1'b0;
        #12;
        check_outputs("reset", 32'h0, 32'h0, 32'h0000_0013, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_outputs("post-release", 32'h0, 32'h0, 32'h0000_0013, 1'b0);

        for (int i = 0; i < 15; i++) begin
            bus.Stall_IF    = vecs[i].stall;
            bus.Redirect_IF = vecs[i].redir;
            bus.Target_IF   = vecs[i].target;
            if (!vecs[i].redir && !vecs[i].stall) exp_fetch++;
            else exp_bubble++;
            @(posedge clk);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_pc_ifid,
                          vecs[i].exp_inst, vecs[i].exp_valid);
`ifdef IF_PERF_CNT_EN
            check($sformatf("vec%0d Fetch_cnt_IF", i), bus.Fetch_cnt_IF, exp_fetch);
            check($sformatf("vec%0d Bubble_cnt_IF", i), bus.Bubble_cnt_IF, exp_bubble);
`endif
        end

        // Asynchronous reset in the middle of a stall cycle.
        bus.Stall_IF    = 1'b1;
        bus.Redirect_IF = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_outputs("async reset", 32'h0, 32'h0, 32'h0000_0013, 1'b0);
`ifdef IF_PERF_CNT_EN
        check("async reset Fetch_cnt_IF", bus.Fetch_cnt_IF, 32'h0);
        check("async reset Bubble_cnt_IF", bus.Bubble_cnt_IF, 32'h0);
`endif
        @(posedge clk);
        #1;
        check_outputs("reset held", 32'h0, 32'h0, 32'h0000_0013, 1'b0);

        bus.Stall_IF = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_outputs("release2", 32'h0, 32'h0, 32'h0000_0013, 1'b0);
        @(posedge clk);
        #1;
        check_outputs("first advance", 32'h4, 32'h0, rom(32'h0), 1'b1);
        @(posedge clk);
        #1;
        check_outputs("second advance", 32'h8, 32'h4, rom(32'h4), 1'b1);
`ifdef IF_PERF_CNT_EN
        check("restart Fetch_cnt_IF", bus.Fetch_cnt_IF, 32'd2);
        check("restart Bubble_cnt_IF", bus.Bubble_cnt_IF, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
